// File: rtl/bayer_pkg.sv
// Shared definitions for the Bayer demosaic block.
//   PAT_*   : encodings of the CFA phase at pixel (0,0)
//   site_e  : colour site of a pixel inside the 2x2 CFA tile
//   site_of : maps row/column parity plus CFA phase to a colour site
package bayer_pkg;

    localparam logic [1:0] PAT_RGGB = 2'd0;
    localparam logic [1:0] PAT_GRBG = 2'd1;
    localparam logic [1:0] PAT_GBRG = 2'd2;
    localparam logic [1:0] PAT_BGGR = 2'd3;

    // Encoding is {row parity, column parity} of an RGGB tile, so every
    // other phase is just an XOR of the parity pair with the phase code.
    typedef enum logic [1:0] {
        SITE_R  = 2'd0,
        SITE_GR = 2'd1,
        SITE_GB = 2'd2,
        SITE_B  = 2'd3
    } site_e;

    function automatic site_e site_of(input logic row_par, input logic col_par,
                                      input logic [1:0] pat);
        return site_e'({row_par, col_par} ^ pat);
    endfunction

endpackage

// File: rtl/shift_line.sv
// One-line delay for a pixel stream, RAM based.
//   clock     : rising-edge clock
//   aclr      : synchronous active-high reset (address and output only)
//   de        : shift enable, one beat per active pixel
//   delay_num : active pixels per line
//   din       : sample to store
//   dout      : sample from the same column one line earlier (1 clock latency)
// The address restarts at every line end, so a line that was cut short
// (e.g. by a reset) cannot leave the columns misaligned for later lines.
module shift_line #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  de,
    input  logic [15:0]           delay_num,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] addr;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (de) mem[addr] <= din;
    end

    // Read-before-write: dout gets the previous line's sample at this column.
    always_ff @(posedge clock) begin
        if (aclr) begin
            addr <= '0;
            dout <= '0;
        end else if (de) begin
            dout <= mem[addr];
            if (32'(addr) + 32'd1 >= 32'(delay_num)) addr <= '0;
            else                                     addr <= addr + ADDR_WIDTH'(1);
        end else begin
            addr <= '0;
        end
    end

endmodule

// File: rtl/bayer_demosaic.sv
// Bilinear Bayer demosaic, 3x3 window, 4-clock latency from i_de to o_de.
//   clock, aclr           : clock and synchronous active-high reset
//   h_active              : active pixels per line (static within a frame)
//   i_vs, i_de, i_raw     : frame sync, pixel strobe, raw CFA sample
//   o_vs, o_de            : syncs delayed 4 clocks
//   o_r, o_g, o_b         : interpolated colour, zero whenever o_de is low
// Optional: define BAYER_BORDER_ZERO_EN to blank the first/last output
// column and the first output row of each frame.
// Pipeline: s1 line-buffer 1 read, s2 line-buffer 2 read, s3 window shift,
// s4 interpolation into the output registers.
module bayer_demosaic
    import bayer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int BAYER_PAT  = 0
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic [15:0]           h_active,
    input  logic                  i_vs,
    input  logic                  i_de,
    input  logic [DATA_WIDTH-1:0] i_raw,
    output logic                  o_vs,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_r,
    output logic [DATA_WIDTH-1:0] o_g,
    output logic [DATA_WIDTH-1:0] o_b
);

    localparam int SW = DATA_WIDTH + 2;

    function automatic logic [DATA_WIDTH-1:0] avg2(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        return s[DATA_WIDTH:1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] avg4(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic [DATA_WIDTH-1:0] c,
                                                   input logic [DATA_WIDTH-1:0] d);
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b) + SW'(c) + SW'(d);
        return s[SW-1:2];
    endfunction

    // Parity of the incoming sample (line n, column c).
    logic col_par, row_par, de_q, vs_q;

    always_ff @(posedge clock) begin
        if (aclr) begin
            col_par <= 1'b0;
            row_par <= 1'b0;
            de_q    <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            de_q <= i_de;
            vs_q <= i_vs;
            if (i_de)      col_par <= ~col_par;
            else if (de_q) col_par <= 1'b0;
            if (i_vs && !vs_q)      row_par <= 1'b0;
            else if (!i_de && de_q) row_par <= ~row_par;
        end
    end

    logic [3:1]            de_pipe, vs_pipe;
    logic [1:0]            par1, par2, ctr_par;
    logic [DATA_WIDTH-1:0] raw1, row1_1, row0_2, row1_2, row2_2;
    // win[row][col]: row 0 = newest line, col 2 = newest column.
    logic [2:0][2:0][DATA_WIDTH-1:0] win;

    shift_line #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_line1 (
        .clock(clock), .aclr(aclr), .de(i_de), .delay_num(h_active),
        .din(i_raw), .dout(row1_1)
    );

    shift_line #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_line2 (
        .clock(clock), .aclr(aclr), .de(de_pipe[1]), .delay_num(h_active),
        .din(row1_1), .dout(row2_2)
    );

    always_ff @(posedge clock) begin
        if (aclr) begin
            de_pipe <= '0;
            vs_pipe <= '0;
            par1    <= '0;
            par2    <= '0;
            ctr_par <= '0;
            raw1    <= '0;
            row0_2  <= '0;
            row1_2  <= '0;
            win     <= '0;
        end else begin
            de_pipe <= {de_pipe[2:1], i_de};
            vs_pipe <= {vs_pipe[2:1], i_vs};
            raw1    <= i_raw;
            par1    <= {row_par, col_par};
            row0_2  <= raw1;
            row1_2  <= row1_1;
            par2    <= par1;
            if (de_pipe[2]) begin
                win[0]  <= {row0_2, win[0][2], win[0][1]};
                win[1]  <= {row1_2, win[1][2], win[1][1]};
                win[2]  <= {row2_2, win[2][2], win[2][1]};
                // Centre sits one line up and one column left of the new sample.
                ctr_par <= ~par2;
            end
        end
    end

    logic blank;

`ifdef BAYER_BORDER_ZERO_EN
    logic [15:0] col_cnt;
    logic        first_row, border3;

    always_ff @(posedge clock) begin
        if (aclr) begin
            col_cnt   <= '0;
            first_row <= 1'b0;
            border3   <= 1'b0;
        end else begin
            if (de_pipe[2]) col_cnt <= col_cnt + 16'd1;
            else            col_cnt <= '0;
            if (de_pipe[2])
                border3 <= (col_cnt == 16'd0) || (col_cnt == h_active - 16'd1) || first_row;
            if (vs_pipe[2] && !vs_pipe[3])      first_row <= 1'b1;
            else if (!de_pipe[2] && de_pipe[3]) first_row <= 1'b0;
        end
    end

    assign blank = border3;
`else
    assign blank = 1'b0;
`endif

    site_e                 site;
    logic [DATA_WIDTH-1:0] r_c, g_c, b_c, cross4, diag4;

    always_comb begin
        site   = site_of(ctr_par[1], ctr_par[0], 2'(BAYER_PAT));
        cross4 = avg4(win[2][1], win[0][1], win[1][0], win[1][2]);
        diag4  = avg4(win[0][0], win[0][2], win[2][0], win[2][2]);
        r_c    = '0;
        g_c    = '0;
        b_c    = '0;
        case (site)
            SITE_R: begin
                r_c = win[1][1];
                g_c = cross4;
                b_c = diag4;
            end
            SITE_B: begin
                b_c = win[1][1];
                g_c = cross4;
                r_c = diag4;
            end
            SITE_GR: begin
                g_c = win[1][1];
                r_c = avg2(win[1][0], win[1][2]);
                b_c = avg2(win[2][1], win[0][1]);
            end
            default: begin
                g_c = win[1][1];
                r_c = avg2(win[2][1], win[0][1]);
                b_c = avg2(win[1][0], win[1][2]);
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            o_de <= 1'b0;
            o_vs <= 1'b0;
            o_r  <= '0;
            o_g  <= '0;
            o_b  <= '0;
        end else begin
            o_de <= de_pipe[3];
            o_vs <= vs_pipe[3];
            if (de_pipe[3] && !blank) begin
                o_r <= r_c;
                o_g <= g_c;
                o_b <= b_c;
            end else begin
                o_r <= '0;
                o_g <= '0;
                o_b <= '0;
            end
        end
    end

endmodule
